conv_window_p: RTL and testbench
================================

CONV_WINDOW_P -- requirements
Module: conv_window_p

Interface
REQ-001 Parameter PIX_W, default 8, pixel width in bits.
REQ-002 Parameter OUT_W, default PIX_W+4, result width in bits; SHALL be at least PIX_W+4.
REQ-003 Port clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port data_in  input  PIX_W  pixel from the data memory bus.
REQ-006 Port reg_select  input  4  window register index, row-major: 0=p1 .. 8=p9.
REQ-007 Port write_en  input  1  write strobe for the register named by reg_select.
REQ-008 Port shift_col  input  1  one-cycle strobe that slides the window one column left.
REQ-009 Port mode  input  2  kernel select: 00 gaussian, 01 box, 10 edge, 11 centre.
REQ-010 Port start  input  1  one-cycle request to compute the kernel.
REQ-011 Port busy  output  1  high while a computation is in flight.
REQ-012 Port valid  output  1  one-cycle pulse marking a new data_out.
REQ-013 Port data_out  output  OUT_W  kernel result to the B bus.

Function
REQ-014 Window storage SHALL be nine PIX_W registers p1..p9 (rows p1-p3, p4-p6, p7-p9).
REQ-015 write_en with reg_select 0..8 SHALL load data_in into that register; reg_select 9..15 SHALL be ignored.
REQ-016 shift_col SHALL perform p1<=p2, p2<=p3, p4<=p5, p5<=p6, p7<=p8, p8<=p9, with p3, p6 and p9 retained.
REQ-017 When shift_col and write_en coincide, the shift SHALL occur and the write SHALL apply only if it targets p3, p6 or p9 (the write wins there); writes to other indices SHALL be dropped.
REQ-018 Control FSM states: IDLE, CALC, DONE; IDLE->CALC on start; CALC->DONE unconditionally; DONE->IDLE unconditionally.
REQ-019 On entering CALC, the window and mode SHALL be snapshotted; window writes or shifts after that edge SHALL NOT affect the in-flight result.
REQ-020 busy SHALL be high in CALC and DONE; start while busy SHALL be ignored.
REQ-021 Latency: with start sampled at edge N, data_out updates and valid pulses high at edge N+2, for exactly one cycle.
REQ-022 start may be reasserted in the DONE cycle; it is then ignored, and the next start is accepted once the FSM is in IDLE.
REQ-023 gaussian: result = p1+2p2+p3+2p4+4p5+2p6+p7+2p8+p9, zero-extended to OUT_W.
REQ-024 box: result = sum of p1..p9, zero-extended to OUT_W.
REQ-025 edge: e = |p1-p3|+|p4-p6|+|p7-p9|, saturated to 2^PIX_W-1, then shifted left by 4.
REQ-026 centre: result = p5 shifted left by 4.
REQ-027 All arithmetic SHALL be unsigned and carried without overflow at OUT_W.
REQ-028 data_out SHALL hold its last result between valid pulses.

Reset
REQ-029 While rst is high at a rising edge, the following SHALL clear: p1..p9=0, FSM=IDLE, busy=0, valid=0, data_out=0.
REQ-030 rst has priority over write_en, shift_col and start in the same cycle.
REQ-031 rst asserted during CALC or DONE SHALL abort the computation with no valid pulse.

Structure
REQ-032 The shared package conv_window_pkg SHALL hold the mode encodings, the FSM state type, the gaussian weight constants and the edge shift amount (4).
REQ-033 A combinational sub-module conv_kernel_alu SHALL compute all four kernels from the snapshot and mode; conv_window_p keeps the registers, the FSM and the output register.

Verification
REQ-034 Gaussian: write p1..p9=1..9, mode=00, start -> valid two cycles later with data_out=80; busy high for exactly 2 cycles.
REQ-035 Saturation: p1=p4=p7=255 and p3=p6=p9=0, mode=10 -> data_out=0xFF0; with all pixels 255, mode=01 -> 2295 and mode=00 -> 4080.
REQ-036 Shift and write collision: window 1..9, shift_col together with write_en reg_select=2 data 50, and separately with reg_select=0 data 77 -> p1..p9 = 2,3,50,5,6,6,8,9,9 and the p1 write dropped.
REQ-037 Snapshot: start, then write p5=200 on the next edge, mode=11 -> data_out equals the old p5<<4; a following start yields 3200.
REQ-038 Reset mid-operation: start, then rst in the CALC cycle -> no valid pulse; data_out=0, busy=0, all pixel registers read 0 via a centre computation; a start while busy is ignored (one valid only).

Source files
------------

// File: rtl/conv_window_pkg.sv
// Shared encodings and constants for the 3x3 convolution window block.
package conv_window_pkg;

  typedef enum logic [1:0] {
    MODE_GAUSS  = 2'b00,
    MODE_BOX    = 2'b01,
    MODE_EDGE   = 2'b10,
    MODE_CENTRE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0]  GW_CORNER    = 3'd1;
  localparam logic [2:0]  GW_SIDE      = 3'd2;
  localparam logic [2:0]  GW_CENTRE    = 3'd4;
  localparam int unsigned EDGE_SHIFT   = 32'd4;
  localparam int unsigned CENTRE_SHIFT = 32'd4;

  // Row-major index 0..8 to gaussian weight.
  function automatic logic [2:0] gauss_weight(input int idx);
    case (idx)
      0, 2, 6, 8: gauss_weight = GW_CORNER;
      1, 3, 5, 7: gauss_weight = GW_SIDE;
      4:          gauss_weight = GW_CENTRE;
      default:    gauss_weight = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/conv_kernel_alu.sv
// Combinational evaluation of the four 3x3 kernels on a snapshotted window.
module conv_kernel_alu
  import conv_window_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int OUT_W = PIX_W + 4
) (
  input  logic [8:0][PIX_W-1:0] win_i,
  input  mode_e                 mode_i,
  output logic [OUT_W-1:0]      result_o
);

  logic [OUT_W-1:0] gauss_s;
  logic [OUT_W-1:0] box_s;
  logic [OUT_W-1:0] edge_s;
  logic [OUT_W-1:0] centre_s;
  logic [PIX_W+1:0] esum_s;
  logic [PIX_W-1:0] esat_s;

  function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    if (a >= b) absdiff = a - b;
    else        absdiff = b - a;
  endfunction

  // Kernel datapath and mode select.
  always_comb begin
    gauss_s = '0;
    box_s   = '0;
    for (int i = 0; i < 9; i++) begin
      gauss_s = gauss_s + OUT_W'(win_i[i]) * OUT_W'(gauss_weight(i));
      box_s   = box_s + OUT_W'(win_i[i]);
    end
    esum_s = (PIX_W+2)'(absdiff(win_i[0], win_i[2]))
           + (PIX_W+2)'(absdiff(win_i[3], win_i[5]))
           + (PIX_W+2)'(absdiff(win_i[6], win_i[8]));
    // Horizontal gradient is clamped to one pixel's range before scaling.
    if (esum_s > {2'b00, {PIX_W{1'b1}}}) esat_s = {PIX_W{1'b1}};
    else                                 esat_s = esum_s[PIX_W-1:0];
    edge_s   = OUT_W'(esat_s) << EDGE_SHIFT;
    centre_s = OUT_W'(win_i[4]) << CENTRE_SHIFT;
    case (mode_i)
      MODE_GAUSS:  result_o = gauss_s;
      MODE_BOX:    result_o = box_s;
      MODE_EDGE:   result_o = edge_s;
      MODE_CENTRE: result_o = centre_s;
      default:     result_o = '0;
    endcase
  end

endmodule

// File: rtl/conv_window_p.sv
// 3x3 pixel window with column shift, snapshot-based kernel evaluation and
// a three-state control FSM giving a fixed two-edge result latency.
module conv_window_p
  import conv_window_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int OUT_W = PIX_W + 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] data_in,
  input  logic [3:0]       reg_select,
  input  logic             write_en,
  input  logic             shift_col,
  input  logic [1:0]       mode,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] data_out
);

  logic [8:0][PIX_W-1:0] win_q, win_d;
  logic [8:0][PIX_W-1:0] snap_q;
  mode_e                 mode_q;
  state_e                state_q, state_d;
  logic                  busy_q, valid_q;
  logic [OUT_W-1:0]      data_out_q;
  logic [OUT_W-1:0]      alu_s;
  logic                  right_col_s;
  logic                  wr_ok_s;

  assign right_col_s = (reg_select == 4'd2) || (reg_select == 4'd5) || (reg_select == 4'd8);
  assign wr_ok_s     = write_en && (reg_select < 4'd9) && (!shift_col || right_col_s);

  // Window next state: shift first, then a surviving write overrides.
  always_comb begin
    win_d = win_q;
    if (shift_col) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
    end else begin
      win_d = win_q;
    end
    if (wr_ok_s) begin
      win_d[reg_select] = data_in;
    end else begin
      win_d[reg_select] = win_d[reg_select];
    end
  end

  // Control FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CALC;
        else       state_d = ST_IDLE;
      end
      ST_CALC: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  conv_kernel_alu #(.PIX_W(PIX_W), .OUT_W(OUT_W)) u_alu (
    .win_i    (snap_q),
    .mode_i   (mode_q),
    .result_o (alu_s)
  );

  // State, window, snapshot and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q      <= '0;
      snap_q     <= '0;
      mode_q     <= MODE_GAUSS;
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      win_q   <= win_d;
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      valid_q <= (state_q == ST_DONE);
      if (state_q == ST_IDLE && start) begin
        snap_q <= win_q;
        mode_q <= mode_e'(mode);
      end
      if (state_q == ST_DONE) begin
        data_out_q <= alu_s;
      end
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_conv_window_p.sv
// Directed self-checking bench for conv_window_p with hand-computed results.
module tb_conv_window_p;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic [3:0]  reg_select;
  logic        write_en;
  logic        shift_col;
  logic [1:0]  mode;
  logic        start;
  logic        busy;
  logic        valid;
  logic [11:0] data_out;

  int n_cmp = 0;
  int n_err = 0;
  int n_valid;

  conv_window_p #(.PIX_W(8), .OUT_W(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .reg_select (reg_select),
    .write_en   (write_en),
    .shift_col  (shift_col),
    .mode       (mode),
    .start      (start),
    .busy       (busy),
    .valid      (valid),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] idx, input logic [7:0] val);
    write_en   = 1'b1;
    reg_select = idx;
    data_in    = val;
    tick();
    write_en   = 1'b0;
  endtask

  task automatic load9(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                       input logic [7:0] v3, input logic [7:0] v4, input logic [7:0] v5,
                       input logic [7:0] v6, input logic [7:0] v7, input logic [7:0] v8);
    wr(4'd0, v0); wr(4'd1, v1); wr(4'd2, v2);
    wr(4'd3, v3); wr(4'd4, v4); wr(4'd5, v5);
    wr(4'd6, v6); wr(4'd7, v7); wr(4'd8, v8);
  endtask

  // Fixed-latency run: start at edge N, result and valid at edge N+2, hold after.
  task automatic run_kernel(input logic [1:0] m, input logic [11:0] exp, input string tag);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "/busy_n"}, 32'(busy), 32'd1);
    check({tag, "/valid_n"}, 32'(valid), 32'd0);
    tick();
    check({tag, "/busy_n1"}, 32'(busy), 32'd1);
    check({tag, "/valid_n1"}, 32'(valid), 32'd0);
    tick();
    check({tag, "/busy_n2"}, 32'(busy), 32'd0);
    check({tag, "/valid_n2"}, 32'(valid), 32'd1);
    check({tag, "/data"}, 32'(data_out), 32'(exp));
    tick();
    check({tag, "/valid_n3"}, 32'(valid), 32'd0);
    check({tag, "/hold"}, 32'(data_out), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; data_in = 8'd0; reg_select = 4'd0; write_en = 1'b0;
    shift_col = 1'b0; mode = 2'b00; start = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    rst = 1'b0;
    tick();

    // Window 1..9 through every kernel.
    load9(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
    run_kernel(2'b00, 12'd80, "gauss_1_9");
    run_kernel(2'b01, 12'd45, "box_1_9");
    run_kernel(2'b10, 12'd96, "edge_1_9");
    run_kernel(2'b11, 12'd80, "centre_1_9");

    // Out-of-range index must not disturb the window.
    wr(4'd9, 8'd255);
    wr(4'd15, 8'd255);
    run_kernel(2'b01, 12'd45, "box_sel_ignored");

    // Edge saturation and all-max sums.
    load9(8'd255, 8'd7, 8'd0, 8'd255, 8'd7, 8'd0, 8'd255, 8'd7, 8'd0);
    run_kernel(2'b10, 12'hFF0, "edge_sat");
    load9(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    run_kernel(2'b01, 12'd2295, "box_max");
    run_kernel(2'b00, 12'd4080, "gauss_max");
    run_kernel(2'b10, 12'd0, "edge_flat");

    // Shift with a right-column write: expect 2,3,50,5,6,6,8,9,9.
    load9(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
    shift_col = 1'b1;
    wr(4'd2, 8'd50);
    shift_col = 1'b0;
    run_kernel(2'b01, 12'd98, "shwr2_box");
    run_kernel(2'b00, 12'd139, "shwr2_gauss");
    run_kernel(2'b10, 12'd800, "shwr2_edge");
    run_kernel(2'b11, 12'd96, "shwr2_centre");

    // Shift with a dropped p1 write: expect 2,3,3,5,6,6,8,9,9.
    load9(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
    shift_col = 1'b1;
    wr(4'd0, 8'd77);
    shift_col = 1'b0;
    run_kernel(2'b01, 12'd51, "shwr0_box");
    run_kernel(2'b00, 12'd92, "shwr0_gauss");
    run_kernel(2'b10, 12'd48, "shwr0_edge");

    // Snapshot: p5 rewritten on the edge after start does not leak in.
    load9(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
    mode  = 2'b11;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = 2'b00;
    wr(4'd4, 8'd200);
    check("snap_valid_n1", 32'(valid), 32'd0);
    shift_col = 1'b1;
    tick();
    shift_col = 1'b0;
    check("snap_valid", 32'(valid), 32'd1);
    check("snap_data", 32'(data_out), 32'd80);
    tick();
    // The shift moved p6=6 into p5, overwriting the 200.
    run_kernel(2'b11, 12'd96, "snap_after_shift");
    wr(4'd4, 8'd200);
    run_kernel(2'b11, 12'd3200, "snap_next");

    // Start reasserted in CALC and DONE is ignored: exactly one valid.
    mode  = 2'b11;
    start = 1'b1;
    tick();
    tick();
    tick();
    start = 1'b0;
    check("busy_start_valid", 32'(valid), 32'd1);
    check("busy_start_data", 32'(data_out), 32'd3200);
    n_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid) n_valid++;
    end
    check("busy_start_extra", 32'(n_valid), 32'd0);
    check("busy_start_idle", 32'(busy), 32'd0);

    // Reset during CALC aborts with no valid pulse.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_data", 32'(data_out), 32'd0);
    n_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (valid) n_valid++;
    end
    check("abort_no_valid", 32'(n_valid), 32'd0);
    run_kernel(2'b11, 12'd0, "abort_centre");
    run_kernel(2'b01, 12'd0, "abort_box");

    // Reset wins over a same-cycle write and start.
    load9(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
    rst        = 1'b1;
    write_en   = 1'b1;
    reg_select = 4'd4;
    data_in    = 8'd99;
    start      = 1'b1;
    tick();
    rst = 1'b0; write_en = 1'b0; start = 1'b0;
    check("rstpri_busy", 32'(busy), 32'd0);
    tick();
    check("rstpri_valid", 32'(valid), 32'd0);
    run_kernel(2'b01, 12'd0, "rstpri_box");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
